// File: rtl/full_adder32_pkg.sv
// Shared constants for the 32-bit ripple adder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package full_adder32_pkg;

   // Operand/sum width the adder is built and verified at.
   localparam int ADDER_WIDTH = 32;

endpackage : full_adder32_pkg

// File: rtl/full_adder_1bit.sv
// One ripple stage: single-bit full adder.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs continuously.
module full_adder_1bit (
   input  logic a_i,
   input  logic b_i,
   input  logic carry_i,
   output logic sum_o,
   output logic carry_o
);

   logic prop;

   // Propagate term is shared by the sum and the carry-through path.
   always_comb begin
      prop    = a_i ^ b_i;
      sum_o   = prop ^ carry_i;
      carry_o = (a_i & b_i) | (carry_i & prop);
   end

endmodule : full_adder_1bit

// File: rtl/full_adder32.sv
// 32-bit unsigned ripple-carry adder with combinational and registered results.
// Latency: sum_o/carry_o 0 cycles; sum_r_o/carry_r_o 1 cycle.
// Backpressure: none; new operands accepted every cycle.
module full_adder32
   import full_adder32_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic [WIDTH-1:0] sum_r_o,
   output logic             carry_r_o
);

   // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the top bit.
   logic [WIDTH:0] carry;

   assign carry[0] = carry_i;

   // Ripple chain: each stage consumes the previous stage's carry, so an
   // unknown input bit only disturbs the bits at and above it.
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      full_adder_1bit u_fa (
         .a_i     (a_i[i]),
         .b_i     (b_i[i]),
         .carry_i (carry[i]),
         .sum_o   (sum_o[i]),
         .carry_o (carry[i+1])
      );
   end

   assign carry_o = carry[WIDTH];

   // Registered copy of the combinational result; reset clears only this copy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sum_r_o   <= '0;
         carry_r_o <= 1'b0;
      end else begin
         sum_r_o   <= sum_o;
         carry_r_o <= carry_o;
      end
   end

endmodule : full_adder32

// File: tb/tb_full_adder32.sv
// Directed and random checks of the 32-bit ripple adder and its registered copy.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_full_adder32;

   logic        clk_i;
   logic        rst_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        carry_i;
   logic [31:0] sum_o;
   logic        carry_o;
   logic [31:0] sum_r_o;
   logic        carry_r_o;

   int errors;
   int checks;

   logic [32:0] ref_val;
   logic [31:0] ra;
   logic [31:0] rb;
   logic        rc;

   full_adder32 dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .carry_i   (carry_i),
      .sum_o     (sum_o),
      .carry_o   (carry_o),
      .sum_r_o   (sum_r_o),
      .carry_r_o (carry_r_o)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check33(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic c);
      a_i     = a;
      b_i     = b;
      carry_i = c;
      #1;
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      rst_i   = 1'b0;
      a_i     = '0;
      b_i     = '0;
      carry_i = 1'b0;

      // Zero operands, combinational then registered after one edge.
      #1;
      check33("zero_comb", {carry_o, sum_o}, 33'h0_0000_0000);
      @(posedge clk_i);
      #1;
      check33("zero_reg", {carry_r_o, sum_r_o}, 33'h0_0000_0000);

      // Directed boundary vectors, hand-computed results.
      apply(32'h0000_0001, 32'h0000_0001, 1'b1);
      check33("one_one_cin", {carry_o, sum_o}, 33'h0_0000_0003);
      apply(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      check33("maxpos_x2", {carry_o, sum_o}, 33'h0_FFFF_FFFE);
      apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check33("allones_x2", {carry_o, sum_o}, 33'h1_FFFF_FFFE);
      apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      check33("allones_x2_cin", {carry_o, sum_o}, 33'h1_FFFF_FFFF);
      apply(32'h8000_0000, 32'h8000_0000, 1'b0);
      check33("msb_x2", {carry_o, sum_o}, 33'h1_0000_0000);
      apply(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      check33("full_ripple", {carry_o, sum_o}, 33'h1_0000_0000);
      apply(32'h1111_1111, 32'h1111_1111, 1'b0);
      check33("nibble_ones", {carry_o, sum_o}, 33'h0_2222_2222);
      apply(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
      check33("alt_cin", {carry_o, sum_o}, 33'h1_0000_0000);
      apply(32'h1234_5678, 32'h0FED_CBA8, 1'b0);
      check33("mixed", {carry_o, sum_o}, 33'h0_2222_2220);

      // Random vectors against a 33-bit reference sum.
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom_range(1, 0));
         apply(ra, rb, rc);
         ref_val = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
         check33("random", {carry_o, sum_o}, ref_val);
      end

      // Reset held for two edges: registers zero, combinational path unaffected.
      @(negedge clk_i);
      rst_i   = 1'b1;
      a_i     = 32'hFFFF_FFFF;
      b_i     = 32'h0000_0001;
      carry_i = 1'b0;
      for (int e = 0; e < 2; e++) begin
         @(posedge clk_i);
         #1;
         check33("rst_reg", {carry_r_o, sum_r_o}, 33'h0_0000_0000);
         check33("rst_comb", {carry_o, sum_o}, 33'h1_0000_0000);
      end

      // First edge out of reset captures the current operands.
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      check33("post_rst_reg", {carry_r_o, sum_r_o}, 33'h1_0000_0000);

      // Combinational result moves at once; registered copy waits for the edge.
      a_i = 32'h0000_0005;
      #1;
      check33("a5_comb", {carry_o, sum_o}, 33'h0_0000_0006);
      check33("a5_reg_hold", {carry_r_o, sum_r_o}, 33'h1_0000_0000);
      @(posedge clk_i);
      #1;
      check33("a5_reg", {carry_r_o, sum_r_o}, 33'h0_0000_0006);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_full_adder32
